// File: rtl/prog_ram.sv
// Program RAM: synchronous-read word memory with direct writes, a burst loader and a whole-memory clear.
// Optional per-word even parity is enabled by defining PROG_RAM_PARITY_EN.
module prog_ram #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              clr_start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              par_err
);
    localparam int DEPTH = 2**ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   rem;

    // Contents power up zero and are deliberately outside the reset domain.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // Single write port shared by direct writes, load beats and clear.
    always_comb begin
        we    = 1'b0;
        waddr = wr_addr;
        wdata = wr_data;
        case (state)
            S_IDLE, S_DONE: we = wr_en;
            S_LOAD: begin
                we    = ld_valid && !abort;
                waddr = ptr;
                wdata = ld_data;
            end
            S_CLEAR: begin
                we    = !abort;
                waddr = ptr;
                wdata = '0;
            end
            default: we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rd_data  = mem[rd_addr_q];
    assign ld_ready = (state == S_LOAD);
    assign busy     = (state == S_LOAD) || (state == S_CLEAR);
    assign done     = (state == S_DONE);

    // LOAD and CLEAR share ptr/rem: CLEAR is a DEPTH-word sweep from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rd_addr_q <= '0;
            ptr       <= '0;
            rem       <= '0;
        end else begin
            rd_addr_q <= rd_addr;
            case (state)
                S_IDLE: begin
                    if (clr_start) begin
                        state <= S_CLEAR;
                        ptr   <= '0;
                        rem   <= (ADDR_W+1)'(DEPTH);
                    end else if (ld_start) begin
                        if (ld_len != '0) begin
                            state <= S_LOAD;
                            ptr   <= ld_base;
                            rem   <= ld_len;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (ld_valid) begin
                        ptr <= ptr + ADDR_W'(1);
                        rem <= rem - (ADDR_W+1)'(1);
                        if (rem == (ADDR_W+1)'(1)) state <= S_DONE;
                    end
                end
                S_CLEAR: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                        rem <= rem - (ADDR_W+1)'(1);
                        if (rem == (ADDR_W+1)'(1)) state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PROG_RAM_PARITY_EN
    logic par_mem [DEPTH] = '{default: 1'b0};

    always_ff @(posedge clk) begin
        if (we) par_mem[waddr] <= ^wdata;
    end

    assign par_err = ^{rd_data, par_mem[rd_addr_q]};
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_ram.sv
// Self-checking bench for prog_ram: vector table, corner-case sequences and
// randomized traffic against an array model of the memory.
module tb_prog_ram;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk, rst_n;
    logic [AW-1:0] rd_addr, wr_addr, ld_base;
    logic [DW-1:0] rd_data, wr_data, ld_data;
    logic [AW:0]   ld_len;
    logic          wr_en, ld_start, ld_valid, ld_ready, clr_start, abort;
    logic          busy, done, par_err;

    prog_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .clr_start(clr_start), .abort(abort), .busy(busy), .done(done),
        .par_err(par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [DW-1:0] model [DEPTH];

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vt [6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick;
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic rd_chk(input string name, input int a);
        rd_addr = AW'(a);
        tick;
        check(name, rd_data, model[a]);
        check({name, "_par"}, par_err, 0);
    endtask

    task automatic verify_all(input string name);
        for (int a = 0; a < DEPTH; a++) rd_chk($sformatf("%s[%0d]", name, a), a);
    endtask

    task automatic fill_nonzero;
        for (int a = 0; a < DEPTH; a++) wr(a, DW'($urandom_range(15, 1)));
    endtask

    // gap: 0 = back-to-back beats, 1 = idle cycle before every beat, 2 = random idles
    task automatic load_run(input string name, input int base, input int len, input int gap);
        int d0;
        logic [DW-1:0] d;
        d0 = done_cnt;
        ld_start = 1'b1; ld_base = AW'(base); ld_len = (AW+1)'(len);
        tick;
        ld_start = 1'b0;
        check({name, "_busy"}, busy, 1);
        check({name, "_ready"}, ld_ready, 1);
        for (int i = 0; i < len; i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(1, 0) == 1)) begin
                ld_valid = 1'b0;
                tick;
            end
            d = (gap == 2) ? DW'($urandom) : DW'(i + 1);
            ld_valid = 1'b1; ld_data = d;
            model[(base + i) % DEPTH] = d;
            tick;
        end
        ld_valid = 1'b0;
        check({name, "_done"}, done, 1);
        check({name, "_busy_end"}, busy, 0);
        tick;
        check({name, "_done_low"}, done, 0);
        check({name, "_done_cnt"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0, bc, op;
        rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
        clr_start = 1'b0; abort = 1'b0;
        for (int a = 0; a < DEPTH; a++) model[a] = '0;

        vt[0] = '{waddr: 4'd3,  wdata: 4'hA, raddr: 4'd3,  exp: 4'hA};
        vt[1] = '{waddr: 4'd7,  wdata: 4'hC, raddr: 4'd5,  exp: 4'h0};
        vt[2] = '{waddr: 4'd0,  wdata: 4'hF, raddr: 4'd0,  exp: 4'hF};
        vt[3] = '{waddr: 4'd15, wdata: 4'h1, raddr: 4'd15, exp: 4'h1};
        vt[4] = '{waddr: 4'd3,  wdata: 4'h6, raddr: 4'd3,  exp: 4'h6};
        vt[5] = '{waddr: 4'd8,  wdata: 4'h9, raddr: 4'd7,  exp: 4'hC};

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_rd_data", rd_data, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick;

        for (int i = 0; i < 6; i++) begin
            wr(vt[i].waddr, vt[i].wdata);
            rd_addr = vt[i].raddr;
            tick;
            check($sformatf("vec%0d_rd", i), rd_data, vt[i].exp);
        end

        // Write and read of the same address on the same edge returns new data.
        rd_addr = 4'd9; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 4'h5;
        tick;
        wr_en = 1'b0; model[9] = 4'h5;
        check("write_first", rd_data, 4'h5);

        // Wrapping load with gapped beats.
        load_run("load_wrap", 14, 4, 1);
        check("load_m14", model[14], 1);
        verify_all("load_wrap_mem");

        // Clear beats a simultaneous load request.
        fill_nonzero;
        d0 = done_cnt;
        clr_start = 1'b1; ld_start = 1'b1; ld_base = 4'd2; ld_len = 5'd4;
        tick;
        clr_start = 1'b0; ld_start = 1'b0;
        check("clr_ready", ld_ready, 0);
        bc = 0;
        while (busy && bc < 40) begin
            bc++;
            tick;
        end
        check("clr_busy_cycles", bc, 16);
        check("clr_done", done, 1);
        tick;
        check("clr_done_cnt", done_cnt - d0, 1);
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        verify_all("clr_mem");

        // Abort after three beats; a direct write during LOAD is dropped.
        fill_nonzero;
        d0 = done_cnt;
        ld_start = 1'b1; ld_base = 4'd2; ld_len = 5'd8;
        tick;
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = DW'(i + 8);
            model[2 + i] = DW'(i + 8);
            wr_en = (i == 0); wr_addr = 4'd12; wr_data = ~model[12];
            tick;
        end
        wr_en = 1'b0;
        ld_valid = 1'b1; ld_data = 4'hE; abort = 1'b1;
        tick;
        ld_valid = 1'b0; abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", ld_ready, 0);
        check("abort_done", done, 0);
        tick;
        tick;
        check("abort_done_cnt", done_cnt - d0, 0);
        verify_all("abort_mem");

        // Reset in the middle of a clear leaves unswept words intact.
        fill_nonzero;
        clr_start = 1'b1;
        tick;
        clr_start = 1'b0;
        repeat (5) tick;
        for (int a = 0; a < 5; a++) model[a] = '0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick;
        verify_all("mid_rst_mem");

        // Zero-length load: immediate done, no writes.
        d0 = done_cnt;
        ld_start = 1'b1; ld_base = 4'd6; ld_len = '0;
        tick;
        ld_start = 1'b0;
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        tick;
        check("len0_done_low", done, 0);
        check("len0_done_cnt", done_cnt - d0, 1);
        verify_all("len0_mem");

        // Randomized direct writes, reads and loads against the model.
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(6, 0);
            if (op < 3) wr($urandom_range(DEPTH - 1, 0), DW'($urandom));
            else if (op < 6) rd_chk($sformatf("rand_rd%0d", n), $urandom_range(DEPTH - 1, 0));
            else load_run($sformatf("rand_ld%0d", n), $urandom_range(DEPTH - 1, 0),
                          $urandom_range(DEPTH, 1), 2);
        end
        verify_all("rand_final");

`ifdef PROG_RAM_PARITY_EN
        wr(4, 4'h7);
        rd_addr = 4'd4;
        tick;
        check("par_clean", par_err, 0);
        dut.par_mem[4] = ~dut.par_mem[4];
        #1;
        check("par_forced", par_err, 1);
        wr(4, 4'h7);
        check("par_rewrite", par_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prog_ram.md
PROG_RAM -- requirements
Module: prog_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 4, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-004 rd_addr in ADDR_W, read address, registered each clock.
REQ-005 rd_data out DATA_W, contents of word at registered read address.
REQ-006 wr_en in 1, direct write strobe; wr_addr in ADDR_W, write address; wr_data in DATA_W, write data.
REQ-007 ld_start in 1, start burst load; ld_base in ADDR_W, first load address; ld_len in ADDR_W+1, word count 0..DEPTH.
REQ-008 ld_valid in 1, load beat valid; ld_data in DATA_W, load beat data; ld_ready out 1, loader accepts beat.
REQ-009 clr_start in 1, start whole-memory clear; abort in 1, cancel load or clear.
REQ-010 busy out 1, state is LOAD or CLEAR; done out 1, one-cycle completion pulse; par_err out 1, parity error on rd_data.

Function
REQ-011 SHALL read synchronously: rd_addr_q <= rd_addr every clock; rd_data = mem[rd_addr_q] combinationally, giving 1-cycle address-to-data latency.
REQ-012 A write to address A at edge N with rd_addr_q == A after edge N SHALL show new data on rd_data after edge N (write-first).
REQ-013 FSM states SHALL be IDLE, LOAD, CLEAR, DONE.
REQ-014 IDLE: clr_start -> CLEAR; else ld_start with ld_len != 0 -> LOAD; ld_start with ld_len == 0 -> DONE; clr_start wins over ld_start when both asserted.
REQ-015 LOAD entry SHALL latch ptr = ld_base and rem = ld_len; ld_ready = 1 only in LOAD.
REQ-016 Each beat with ld_valid && ld_ready SHALL write ld_data to mem[ptr], ptr increments modulo DEPTH (wraps DEPTH-1 -> 0), rem decrements; beat with rem == 1 SHALL move FSM to DONE.
REQ-017 CLEAR SHALL write zero to one word per cycle, addresses 0 to DEPTH-1 in order, exactly DEPTH cycles, then DONE.
REQ-018 DONE SHALL last one cycle with done = 1, then return to IDLE.
REQ-019 abort in LOAD or CLEAR SHALL return FSM to IDLE at next edge with no write on that edge and no done pulse; already-written words remain; abort in IDLE or DONE ignored.
REQ-020 ld_start and clr_start SHALL be ignored outside IDLE.
REQ-021 wr_en SHALL write only in IDLE or DONE; in LOAD or CLEAR it SHALL be ignored (dropped, not queued).
REQ-022 Memory contents SHALL power up all-zero and SHALL NOT be affected by rst_n.

Reset
REQ-023 rst_n low SHALL immediately force: FSM IDLE, rd_addr_q 0, ptr 0, rem 0, ld_ready 0, busy 0, done 0.
REQ-024 rst_n asserted mid-LOAD or mid-CLEAR SHALL stop further writes; partially written contents remain.
REQ-025 After rst_n deassertion, the first edge SHALL behave as normal IDLE operation.

Configuration
REQ-026 Macro PROG_RAM_PARITY_EN defined: each stored word SHALL carry one extra even-parity bit computed at every write (direct, load, clear); par_err = 1 when parity over rd_data plus stored bit is odd.
REQ-027 Macro PROG_RAM_PARITY_EN undefined: no parity storage; par_err SHALL be tied 0; all other behaviour identical.

Verification
REQ-028 After reset, wr_en with wr_addr=3, wr_data=0xA, then rd_addr=3 -> rd_data=0xA one cycle after rd_addr is applied; rd_addr=5 -> 0x0.
REQ-029 ld_start with ld_base=14, ld_len=4, beats 1,2,3,4 with ld_valid gapped every other cycle -> mem[14]=1, mem[15]=2, mem[0]=3, mem[1]=4, single done pulse, busy low afterwards.
REQ-030 Memory preloaded non-zero, clr_start and ld_start in the same cycle -> CLEAR taken, busy high exactly 16 cycles (default params), done pulse, all words read 0x0.
REQ-031 LOAD ld_len=8, abort after 3 beats -> 3 words written, no done pulse, FSM IDLE; wr_en issued during LOAD had no effect.
REQ-032 rst_n pulsed low mid-CLEAR -> busy and done 0 immediately, remaining words unchanged; ld_start with ld_len=0 after reset -> done pulse next cycle, no writes.
REQ-033 With PROG_RAM_PARITY_EN defined: write 0x7 then force the stored parity bit by backdoor -> par_err=1 on read; normal reads -> par_err=0.
